// File: rtl/spi_master_cmd.sv
// SPI mode-0 command initiator: one accepted command becomes one cs_n frame (opcode + payload),
// cmd_ready only in IDLE; FEEDBACK frames return the 32-bit word with a rsp_valid pulse at cs_n rise.
module spi_master_cmd #(
  parameter int CLK_DIV  = 4,
  parameter int BYTE_GAP = 8,
  parameter int CS_SETUP = 4,
  parameter int CS_HOLD  = 4,
  parameter int CS_IDLE  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [15:0] cmd_data,
  output logic        busy,
  output logic        cmd_err,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        sclk,
  output logic        mosi,
  input  logic        miso,
  output logic        cs_n
);
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, GAP, HOLD, DESEL} state_t;

  localparam logic [2:0]  OP_FEEDBACK = 3'd6;
  localparam logic [2:0]  OP_RSVD     = 3'd7;
  localparam logic [15:0] DIV_C       = 16'(CLK_DIV);
  localparam logic [15:0] BIT_END     = 16'(2 * CLK_DIV - 1);
  localparam logic [15:0] SETUP_END   = 16'(CS_SETUP - 1);
  localparam logic [15:0] GAP_END     = 16'(BYTE_GAP - 1);
  localparam logic [15:0] HOLD_END    = 16'(CS_HOLD - 1);
  localparam logic [15:0] IDLE_END    = 16'(CS_IDLE - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [2:0]  byte_q, byte_d;
  logic [2:0]  op_q, op_d;
  logic [15:0] data_q, data_d;
  logic [31:0] shadow_q, shadow_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        busy_q, busy_d;
  logic        cmd_err_q, cmd_err_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        mosi_q, mosi_d;
  logic [7:0]  tx_byte;
  logic [2:0]  last_byte;
  logic [4:0]  rx_idx;
  logic        accept;

  assign accept    = cmd_valid && (state_q == IDLE);
  assign cmd_ready = (state_q == IDLE);
  assign busy      = busy_q;
  assign cmd_err   = cmd_err_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign cs_n      = (state_q == IDLE) || (state_q == DESEL);
  assign sclk      = (state_q == SHIFT) && (cnt_q >= DIV_C);
  assign mosi      = (state_q == SHIFT) ? tx_byte[bit_q] : mosi_q;
  // Dummy byte k lands in rsp[8k-1:8k-8], MSB first.
  assign rx_idx    = {2'(byte_q - 3'd1), bit_q};

  always_comb begin
    case (op_q)
      3'd0, 3'd1:  last_byte = 3'd0;
      OP_FEEDBACK: last_byte = 3'd4;
      default:     last_byte = 3'd2;
    endcase
  end

  always_comb begin
    tx_byte = 8'h00;
    if (byte_q == 3'd0) begin
      case (op_q)
        3'd0:    tx_byte = 8'h06;
        3'd1:    tx_byte = 8'h04;
        3'd2:    tx_byte = 8'h91;
        3'd3:    tx_byte = 8'h9E;
        3'd4:    tx_byte = 8'h93;
        3'd5:    tx_byte = 8'h9C;
        3'd6:    tx_byte = 8'hAB;
        default: tx_byte = 8'h00;
      endcase
    end else if (op_q != OP_FEEDBACK) begin
      tx_byte = (byte_q == 3'd1) ? data_q[7:0] : data_q[15:8];
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    byte_d      = byte_q;
    op_d        = op_q;
    data_d      = data_q;
    shadow_d    = shadow_q;
    rsp_data_d  = rsp_data_q;
    busy_d      = busy_q;
    mosi_d      = mosi_q;
    cmd_err_d   = 1'b0;
    rsp_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (accept) begin
          op_d   = cmd_op;
          data_d = cmd_data;
          busy_d = 1'b1;
          if (cmd_op == OP_RSVD) begin
            cmd_err_d = 1'b1;
          end else begin
            state_d  = SETUP;
            cnt_d    = '0;
            byte_d   = '0;
            bit_d    = 3'd7;
            shadow_d = '0;
          end
        end
      end
      SETUP: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == SETUP_END) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        mosi_d = tx_byte[bit_q];
        cnt_d  = cnt_q + 16'd1;
        if (cnt_q == DIV_C && op_q == OP_FEEDBACK && byte_q != 3'd0) begin
          shadow_d[rx_idx] = miso;
        end
        if (cnt_q == BIT_END) begin
          cnt_d = '0;
          bit_d = bit_q - 3'd1;
          if (bit_q == 3'd0) begin
            bit_d = 3'd7;
            if (byte_q == last_byte) begin
              state_d = HOLD;
            end else begin
              state_d = GAP;
              byte_d  = byte_q + 3'd1;
            end
          end
        end
      end
      GAP: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == GAP_END) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end
      end
      HOLD: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == HOLD_END) begin
          state_d = DESEL;
          cnt_d   = '0;
          if (op_q == OP_FEEDBACK) begin
            rsp_data_d  = shadow_q;
            rsp_valid_d = 1'b1;
          end
        end
      end
      DESEL: begin
        mosi_d = 1'b0;
        cnt_d  = cnt_q + 16'd1;
        if (cnt_q == IDLE_END) begin
          state_d = IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= 3'd7;
      byte_q      <= '0;
      op_q        <= '0;
      data_q      <= '0;
      shadow_q    <= '0;
      busy_q      <= 1'b0;
      mosi_q      <= 1'b0;
      cmd_err_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      // A reset that cuts a frame short keeps the last feedback word.
      if (!busy_q) rsp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      byte_q      <= byte_d;
      op_q        <= op_d;
      data_q      <= data_d;
      shadow_q    <= shadow_d;
      busy_q      <= busy_d;
      mosi_q      <= mosi_d;
      cmd_err_q   <= cmd_err_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end
endmodule

// File: tb/tb_spi_master_cmd.sv
// Bench for spi_master_cmd: frames and feedback words are queued by the stimulus and
// checked by a monitor acting as the SPI slave.
module tb_spi_master_cmd;
  localparam int CLK_DIV  = 4;
  localparam int BYTE_GAP = 8;
  localparam int CS_SETUP = 4;
  localparam int CS_HOLD  = 4;
  localparam int CS_IDLE  = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [2:0]  cmd_op = 3'd0;
  logic [15:0] cmd_data = 16'd0;
  logic        cmd_ready, busy, cmd_err, rsp_valid, sclk, mosi, miso, cs_n;
  logic [31:0] rsp_data;

  always #5 clk = ~clk;

  spi_master_cmd #(
    .CLK_DIV(CLK_DIV), .BYTE_GAP(BYTE_GAP), .CS_SETUP(CS_SETUP),
    .CS_HOLD(CS_HOLD), .CS_IDLE(CS_IDLE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .busy(busy), .cmd_err(cmd_err),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .sclk(sclk), .mosi(mosi),
    .miso(miso), .cs_n(cs_n)
  );

  // n == 0 marks a frame that is expected to be cut short by reset.
  typedef struct packed {
    logic [3:0]  n;
    logic [39:0] bits;
  } frame_t;

  frame_t      exp_q[$];
  logic [31:0] rsp_q[$];
  int          tests = 0;
  int          fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int busy_len(input int n);
    return CS_SETUP + n * 16 * CLK_DIV + (n - 1) * BYTE_GAP + CS_HOLD + CS_IDLE;
  endfunction

  // Slave model: miso shifts MSB first, advancing on each sclk fall.
  logic [39:0] s_tx = 40'd0;
  logic [5:0]  s_t = 6'd0;
  assign miso = (cs_n === 1'b0 && s_t < 6'd40) ? s_tx[6'd39 - s_t] : 1'b0;

  logic        prev_cs = 1'b1;
  logic        prev_sclk = 1'b0;
  logic        seen_end = 1'b0;
  logic [39:0] rx = 40'd0;
  int          cyc = 0, fall_t = 0, first_rise = 0, last_rise = 0, last_fall = 0;
  int          bits = 0, idle_cyc = 0, bad_period = 0;
  frame_t      f;
  logic [31:0] r;

  always @(negedge clk) begin
    cyc++;
    if (rsp_valid === 1'b1) begin
      chk("rsp_at_cs_rise", 64'({prev_cs, cs_n}), 64'b01);
      chk("rsp_expected", 64'(rsp_q.size() != 0), 64'd1);
      if (rsp_q.size() != 0) begin
        r = rsp_q.pop_front();
        chk("rsp_data", 64'(rsp_data), 64'(r));
      end
    end
    if (prev_cs === 1'b1 && cs_n === 1'b0) begin
      if (seen_end) chk("cs_idle_min", 64'(idle_cyc >= CS_IDLE), 64'd1);
      fall_t = cyc; bits = 0; rx = 40'd0; bad_period = 0; s_t = 6'd0;
    end
    if (cs_n === 1'b0) begin
      if (prev_sclk === 1'b0 && sclk === 1'b1) begin
        if (bits == 0) first_rise = cyc;
        else if (bits % 8 == 0) begin
          if (cyc - last_rise != 2 * CLK_DIV + BYTE_GAP) bad_period++;
        end else if (cyc - last_rise != 2 * CLK_DIV) bad_period++;
        rx = {rx[38:0], mosi};
        bits++;
        last_rise = cyc;
      end
      if (prev_sclk === 1'b1 && sclk === 1'b0) begin
        last_fall = cyc;
        s_t = s_t + 6'd1;
      end
    end
    if (prev_cs === 1'b0 && cs_n === 1'b1) begin
      chk("frame_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        f = exp_q.pop_front();
        if (f.n == 4'd0) begin
          seen_end = 1'b0;
        end else begin
          chk("frame_sclk_pulses", 64'(bits), 64'(8 * f.n));
          chk("frame_mosi_bytes", 64'(rx), 64'(f.bits));
          chk("cs_fall_to_first_rise", 64'(first_rise - fall_t), 64'(CS_SETUP + CLK_DIV));
          chk("last_fall_to_cs_rise", 64'(cyc - last_fall), 64'(CS_HOLD));
          chk("frame_cs_low_cycles", 64'(cyc - fall_t),
              64'(CS_SETUP + f.n * 16 * CLK_DIV + (f.n - 1) * BYTE_GAP + CS_HOLD));
          chk("sclk_period_errors", 64'(bad_period), 64'd0);
          seen_end = 1'b1;
        end
      end
      s_t = 6'd0;
    end
    idle_cyc = (cs_n === 1'b1) ? idle_cyc + 1 : 0;
    prev_cs   = cs_n;
    prev_sclk = sclk;
  end

  task automatic wait_ready();
    int t = 0;
    while (cmd_ready !== 1'b1 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (cmd_ready !== 1'b1) chk("cmd_ready_wait", 64'(cmd_ready), 64'd1);
  endtask

  // Called just after an accepting edge; counts cycles until cmd_ready returns.
  task automatic busy_cycles(input int exp_len, input string name);
    int t = 0;
    int b = 0;
    @(negedge clk);
    while (cmd_ready !== 1'b1 && t < 2000) begin
      if (busy === 1'b1) b++;
      t++;
      @(negedge clk);
    end
    chk(name, 64'(t), 64'(exp_len));
    chk({name, "_busy"}, 64'(b), 64'(exp_len));
  endtask

  task automatic push_frame(input int n, input logic [39:0] b);
    frame_t e;
    e.n    = 4'(n);
    e.bits = b;
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic [2:0] op, input logic [15:0] d, input int n, input logic [39:0] b);
    @(negedge clk);
    wait_ready();
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
    push_frame(n, b);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0; cmd_data = ~d;
    busy_cycles(busy_len(n), "busy_len");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rst_cs_n", 64'(cs_n), 64'd1);
    chk("rst_sclk", 64'(sclk), 64'd0);
    chk("rst_mosi", 64'(mosi), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_cmd_err", 64'(cmd_err), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_data", 64'(rsp_data), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 64'(cmd_ready), 64'd1);

    issue(3'd0, 16'hFFFF, 1, 40'h06);
    issue(3'd2, 16'h1234, 3, 40'h913412);

    s_tx = 40'h55_EF_BE_AD_DE;
    rsp_q.push_back(32'hDEADBEEF);
    issue(3'd6, 16'hA5A5, 5, 40'hAB_00_00_00_00);
    s_tx = 40'd0;
    chk("rsp_data_held", 64'(rsp_data), 64'h0DEADBEEF);

    // cmd_valid held high across two commands
    @(negedge clk);
    wait_ready();
    cmd_valid = 1'b1; cmd_op = 3'd4; cmd_data = 16'h001E;
    push_frame(3, 40'h931E00);
    @(posedge clk);
    #1;
    cmd_op = 3'd5; cmd_data = 16'h0003;
    push_frame(3, 40'h9C0300);
    busy_cycles(busy_len(3), "b2b_first");
    @(posedge clk);
    #1;
    cmd_valid = 1'b0; cmd_data = 16'hFFFF;
    busy_cycles(busy_len(3), "b2b_second");

    // reset during byte 2 of a TOFF frame
    @(negedge clk);
    wait_ready();
    cmd_valid = 1'b1; cmd_op = 3'd3; cmd_data = 16'hBEEF;
    push_frame(0, 40'd0);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (100) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("abort_cs_n", 64'(cs_n), 64'd1);
    chk("abort_sclk", 64'(sclk), 64'd0);
    chk("abort_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("abort_rsp_data", 64'(rsp_data), 64'h0DEADBEEF);
    chk("abort_busy", 64'(busy), 64'd0);
    issue(3'd1, 16'h0000, 1, 40'h04);

    // reserved opcode
    @(negedge clk);
    wait_ready();
    cmd_valid = 1'b1; cmd_op = 3'd7; cmd_data = 16'h5555;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk("op7_cmd_err", 64'(cmd_err), 64'd1);
    chk("op7_ready", 64'(cmd_ready), 64'd1);
    chk("op7_cs_n", 64'(cs_n), 64'd1);
    @(negedge clk);
    chk("op7_cmd_err_clear", 64'(cmd_err), 64'd0);
    chk("op7_mosi_idle", 64'(mosi), 64'd0);

    repeat (40) @(negedge clk);
    chk("frames_outstanding", 64'(exp_q.size()), 64'd0);
    chk("rsp_outstanding", 64'(rsp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
